// File: rtl/pc_fetch_if.sv
// Bus between the control unit side and the PC/fetch stage.
// Handshake: the stage has no valid/ready pair. It stalls on its own when halt
// is high in RUN, holds pc until a fresh in_button rising edge is seen, then
// emits in_strobe for one cycle. run_en is a level gate, not a handshake.
interface pc_fetch_if #(
  parameter int PC_WIDTH = 10
);
  logic                run_en;
  logic                desvio;
  logic                type_jr;
  logic                is_cond;
  logic                cond_ok;
  logic                halt;
  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] jr_target;
  logic                in_button;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_plus1;
  logic                commit;
  logic                in_strobe;
  logic                waiting_in;
  logic [1:0]          state_dbg;

  modport master (
    output run_en, desvio, type_jr, is_cond, cond_ok, halt,
           jump_target, jr_target, in_button,
    input  pc, pc_plus1, commit, in_strobe, waiting_in, state_dbg
  );

  modport slave (
    input  run_en, desvio, type_jr, is_cond, cond_ok, halt,
           jump_target, jr_target, in_button,
    output pc, pc_plus1, commit, in_strobe, waiting_in, state_dbg
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencing: next-PC selection, IN-instruction
// stall on an operator button, and the commit strobe for architectural writes.
module pc_fetch_unit #(
  parameter int PC_WIDTH    = 10,
  parameter int RESET_PC    = 0,
  parameter int SYNC_STAGES = 2
) (
  input logic       clock,
  input logic       reset_n,
  pc_fetch_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT_IN = 2'd1,
    ST_ACK     = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [PC_WIDTH-1:0]      pc_q, pc_d;
  logic [PC_WIDTH-1:0]      pc_plus1;
  logic [PC_WIDTH-1:0]      next_pc;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic [SYNC_STAGES-1:0]   fill_q;
  logic                     prev_q;
  logic                     btn_edge;
  logic                     commit_c;
  logic                     in_strobe_c;
  logic                     waiting_in_c;

  assign pc_plus1 = pc_q + PC_WIDTH'(1);

  // Button synchronizer plus a fill marker that tracks how many stages hold
  // post-reset samples.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.in_button};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Previous-sample register. It stays at 1 until the synchronizer is filled,
  // so a button held through reset reads as "already high" and never edges.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) prev_q <= 1'b1;
    else if (!fill_q[SYNC_STAGES-1]) prev_q <= 1'b1;
    else prev_q <= sync_q[SYNC_STAGES-1];
  end

  assign btn_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Next-PC priority: JR, then taken jump/branch, then sequential.
  always_comb begin
    next_pc = pc_plus1;
    if (bus.type_jr && bus.desvio) next_pc = bus.jr_target;
    else if (bus.desvio && (!bus.is_cond || bus.cond_ok)) next_pc = bus.jump_target;
  end

  // State and PC registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      pc_q    <= PC_WIDTH'(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // FSM next state and decoded outputs. A desvio wins over a simultaneous
  // halt, so a branch never stalls.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    commit_c     = 1'b0;
    in_strobe_c  = 1'b0;
    waiting_in_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.run_en) begin
          if (bus.halt && !bus.desvio) begin
            state_d = ST_WAIT_IN;
          end else begin
            commit_c = 1'b1;
            pc_d     = next_pc;
          end
        end
      end
      ST_WAIT_IN: begin
        waiting_in_c = 1'b1;
        if (btn_edge) state_d = ST_ACK;
      end
      ST_ACK: begin
        in_strobe_c = 1'b1;
        commit_c    = 1'b1;
        pc_d        = pc_plus1;
        state_d     = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus1   = pc_plus1;
  assign bus.commit     = commit_c;
  assign bus.in_strobe  = in_strobe_c;
  assign bus.waiting_in = waiting_in_c;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed cycles push expected outputs, a monitor
// pops and compares on every falling edge.
module tb_pc_fetch_unit;
  localparam int PW = 10;
  localparam int W  = 2 * PW + 3;

  logic clock;
  logic reset_n;
  pc_fetch_if #(.PC_WIDTH(PW)) bus ();

  pc_fetch_unit #(.PC_WIDTH(PW), .RESET_PC(0), .SYNC_STAGES(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input logic [PW-1:0] p, input logic c, input logic s,
                            input logic w);
    logic [PW-1:0] p1;
    p1 = p + 10'd1;
    exp_q.push_back({p, p1, c, s, w});
  endtask

  task automatic step(input logic [PW-1:0] p, input logic c, input logic s,
                      input logic w);
    expect_out(p, c, s, w);
    tick();
  endtask

  task automatic ctl(input logic de, input logic jr, input logic ic, input logic ok,
                     input logic h, input logic [PW-1:0] jt, input logic [PW-1:0] jrt);
    bus.desvio = de; bus.type_jr = jr; bus.is_cond = ic; bus.cond_ok = ok;
    bus.halt = h; bus.jump_target = jt; bus.jr_target = jrt;
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = {bus.pc, bus.pc_plus1, bus.commit, bus.in_strobe, bus.waiting_in};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL out_check t=%0t: got pc=%0d pc1=%0d commit=%b strobe=%b wait=%b, exp pc=%0d pc1=%0d commit=%b strobe=%b wait=%b",
                 $time, a[W-1 -: PW], a[PW+2 -: PW], a[2], a[1], a[0],
                 e[W-1 -: PW], e[PW+2 -: PW], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    bus.run_en = 1'b0;
    bus.in_button = 1'b0;
    ctl(0, 0, 0, 0, 0, '0, '0);
    tick();

    // reset state
    step(10'd0, 0, 0, 0);

    // sequential run 0..5
    reset_n = 1'b1;
    bus.run_en = 1'b1;
    for (int i = 0; i < 6; i++) step(10'(i), 1, 0, 0);
    step(10'd6, 1, 0, 0);

    // conditional not taken, taken, then JR
    ctl(1, 0, 1, 0, 0, 10'd40, 10'd0);
    step(10'd7, 1, 0, 0);
    ctl(1, 0, 1, 1, 0, 10'd40, 10'd0);
    step(10'd8, 1, 0, 0);
    ctl(1, 1, 0, 0, 0, 10'd40, 10'd99);
    step(10'd40, 1, 0, 0);
    ctl(0, 0, 0, 0, 0, '0, '0);
    step(10'd99, 1, 0, 0);

    // wrap 1023 -> 0
    ctl(1, 0, 0, 0, 0, 10'd1023, 10'd0);
    step(10'd100, 1, 0, 0);
    ctl(0, 0, 0, 0, 0, '0, '0);
    step(10'd1023, 1, 0, 0);

    // run_en low freezes pc
    bus.run_en = 1'b0;
    step(10'd0, 0, 0, 0);
    step(10'd0, 0, 0, 0);
    bus.run_en = 1'b1;
    ctl(1, 0, 0, 0, 0, 10'd12, 10'd0);
    step(10'd0, 1, 0, 0);

    // IN stall at 12
    ctl(0, 0, 0, 0, 1, '0, '0);
    step(10'd12, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(10'd12, 0, 0, 1);
    bus.in_button = 1'b1;
    for (int i = 0; i < 3; i++) step(10'd12, 0, 0, 1);
    bus.halt = 1'b0;
    step(10'd12, 1, 1, 0);
    step(10'd13, 1, 0, 0);
    bus.in_button = 1'b0;

    // reset during WAIT_IN at 30
    ctl(1, 0, 0, 0, 0, 10'd30, 10'd0);
    step(10'd14, 1, 0, 0);
    ctl(0, 0, 0, 0, 1, '0, '0);
    step(10'd30, 0, 0, 0);
    step(10'd30, 0, 0, 1);
    bus.in_button = 1'b1;
    reset_n = 1'b0;
    bus.run_en = 1'b0;
    step(10'd0, 0, 0, 0);
    step(10'd0, 0, 0, 0);

    // button held across reset release, IN at pc 0: no strobe until re-press
    reset_n = 1'b1;
    bus.run_en = 1'b1;
    step(10'd0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(10'd0, 0, 0, 1);
    bus.in_button = 1'b0;
    for (int i = 0; i < 3; i++) step(10'd0, 0, 0, 1);
    bus.in_button = 1'b1;
    for (int i = 0; i < 3; i++) step(10'd0, 0, 0, 1);
    bus.halt = 1'b0;
    step(10'd0, 1, 1, 0);
    step(10'd1, 1, 0, 0);

    // drain
    @(negedge clock);
    @(negedge clock);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending, exp 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and fetch-sequencing stage directly upstream of the control unit.
- Supplies the instruction address each cycle and computes the next PC from the control unit's Desvio, TypeJR and Halt outputs.
- Suspends execution on an IN instruction until the operator presses the input button.
- Gates architectural writes through a commit strobe.

Parameters:
- PC_WIDTH, 10, width of PC and all target addresses.
- RESET_PC, 0, PC value loaded on reset.
- SYNC_STAGES, 2, flip-flop depth of the in_button synchronizer (minimum 2).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run_en  in  1  global run enable; 0 freezes the PC and forces commit=0.
- desvio  in  1  control-unit branch/jump request.
- type_jr  in  1  control-unit JR flag; target comes from jr_target.
- is_cond  in  1  1 for BEQ/BNE (conditional), 0 for Jump/JR.
- cond_ok  in  1  branch condition met (from comparator); meaningful only when is_cond=1.
- halt  in  1  control-unit Halt (asserted for IN).
- jump_target  in  PC_WIDTH  immediate target for Jump/BEQ/BNE.
- jr_target  in  PC_WIDTH  register-sourced target for JR.
- in_button  in  1  asynchronous operator confirm button, active-high.
- pc  out  PC_WIDTH  current instruction address (registered).
- pc_plus1  out  PC_WIDTH  pc+1 modulo 2^PC_WIDTH (combinational).
- commit  out  1  current instruction may write regfile/memory/output this cycle.
- in_strobe  out  1  one-cycle pulse: latch switch input into destination register.
- waiting_in  out  1  high while suspended on IN.

Behaviour:
- Reset (async, reset_n=0):
  - pc=RESET_PC; state=RUN; waiting_in=0; in_strobe=0.
  - All synchronizer stages clear to 0; edge-detect previous-sample register sets to 1, so a button held through reset produces no edge until it is released and pressed again.
- Next-PC selection, highest priority first:
  - type_jr & desvio -> jr_target.
  - desvio & (~is_cond | cond_ok) -> jump_target.
  - Otherwise -> pc_plus1.
  - Increment wraps from 2^PC_WIDTH-1 to 0 with no flag.
- State RUN:
  - run_en=0: pc holds; commit=0.
  - run_en=1, halt=0: commit=1; pc <= next-PC.
  - run_en=1, halt=1: commit=0; pc holds; next state WAIT_IN.
  - Button edges seen while in RUN are discarded.
- State WAIT_IN:
  - waiting_in=1; commit=0; pc holds.
  - A synchronized rising edge of in_button moves to ACK. No edge: remain.
  - run_en is ignored.
- State ACK (exactly one cycle):
  - in_strobe=1; commit=1; waiting_in=0.
  - pc <= pc_plus1 (IN never branches); next state RUN.
- Latency:
  - An edge on in_button reaches the edge detector after SYNC_STAGES cycles.
  - ACK follows one cycle later.
- Output timing: commit, in_strobe and waiting_in are decoded from state (commit in RUN also uses run_en/halt). There is no registered delay.
- Simultaneous halt and desvio is illegal; the block gives desvio priority and ignores halt.
- Reset asserted mid-WAIT_IN or ACK: immediate return to RUN at RESET_PC; no in_strobe is emitted.
- Consecutive IN instructions: each needs its own press/release/press edge.

Test Plan:
- Reset, run_en=1, no desvio/halt for 5 cycles -> pc 0,1,2,3,4,5; commit=1 throughout.
- pc=1023 (PC_WIDTH=10), sequential step -> pc=0.
- desvio=1, is_cond=1, cond_ok=0, jump_target=40 at pc=7 -> pc=8. Repeat with cond_ok=1 -> pc=40. type_jr=1, jr_target=99 -> pc=99.
- IN stall at pc=12: halt=1 -> commit=0, waiting_in=1, pc stays 12 for 20 cycles. Press in_button -> after SYNC_STAGES+1 cycles in_strobe pulses exactly one cycle, then pc=13.
- in_button held high across reset release, halt=1 at pc=0 -> no in_strobe until button drops and rises again.
- reset_n pulsed low while in WAIT_IN at pc=30 -> pc=RESET_PC, waiting_in=0, no in_strobe.
